// File: rtl/p_s_converter_if.sv
// Parallel-word handshake and serial output bundle for p_s_converter.
// The producer side uses the master modport; the converter uses the slave modport.
interface p_s_converter_if #(
    parameter int C_BITS_IN = 255
);
    logic [C_BITS_IN-1:0] DIN;
    logic                 DIN_VALID;
    logic                 DIN_READY;
    logic                 Q;
    logic                 FRAME;
    logic                 BUSY;

    modport master (
        output DIN,
        output DIN_VALID,
        input  DIN_READY,
        input  Q,
        input  FRAME,
        input  BUSY
    );

    modport slave (
        input  DIN,
        input  DIN_VALID,
        output DIN_READY,
        output Q,
        output FRAME,
        output BUSY
    );
endinterface

// File: rtl/p_s_converter.sv
// Parallel-to-serial converter: accepts a C_BITS_IN-bit word on a valid/ready
// handshake and shifts it out MSB first on a registered serial line with FRAME/BUSY.
module p_s_converter #(
    parameter int C_BITS_IN = 255
) (
    input  logic            CK,
    input  logic            RST,
    p_s_converter_if.slave  bus
);

    localparam int                CNT_W    = $clog2(C_BITS_IN);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(C_BITS_IN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [C_BITS_IN-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 q_r, q_nxt;
    logic                 frame_r, frame_nxt;
    logic                 busy_r, busy_nxt;
    logic                 last_bit;
    logic                 din_ready;
    logic                 accept;

    // Ready is also raised in the last bit cycle so consecutive words stream without a gap.
    assign last_bit  = (state == SHIFT) && (cnt == LAST_CNT);
    assign din_ready = (state == IDLE) || last_bit;
    assign accept    = din_ready && bus.DIN_VALID;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            q_r     <= 1'b0;
            frame_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            q_r     <= q_nxt;
            frame_r <= frame_nxt;
            busy_r  <= busy_nxt;
        end
    end

    // Q always presents the bit selected one edge earlier, so the MSB goes straight
    // from DIN to Q at acceptance and later bits come from shreg one position down.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        q_nxt     = 1'b0;
        frame_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (accept) begin
            state_nxt = SHIFT;
            shreg_nxt = bus.DIN;
            cnt_nxt   = '0;
            q_nxt     = bus.DIN[C_BITS_IN-1];
            frame_nxt = 1'b1;
            busy_nxt  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                SHIFT: begin
                    if (last_bit) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                        shreg_nxt = shreg << 1;
                        q_nxt     = shreg[C_BITS_IN-2];
                        busy_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.DIN_READY = din_ready;
    assign bus.Q         = q_r;
    assign bus.FRAME     = frame_r;
    assign bus.BUSY      = busy_r;

    frame_implies_busy: assert property (@(posedge CK) disable iff (RST) frame_r |-> busy_r);
    idle_line_low:      assert property (@(posedge CK) disable iff (RST) !busy_r |-> !q_r);

endmodule

// File: doc/p_s_converter.md
P_S_CONVERTER -- requirements
Module: p_s_converter

Interface
REQ-001 SHALL have parameter C_BITS_IN, default 255: parallel word width, legal range 2..1024.
REQ-002 SHALL have port CK, input, 1 bit: the single clock; all state changes on rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port DIN, input, C_BITS_IN bits: parallel word to serialize.
REQ-005 SHALL have port DIN_VALID, input, 1 bit: DIN holds a word to transfer.
REQ-006 SHALL have port DIN_READY, output, 1 bit: block accepts a word at this edge.
REQ-007 SHALL have port Q, output, 1 bit: serial bit stream that feeds the downstream serial-to-parallel D input.
REQ-008 SHALL have port FRAME, output, 1 bit: high during the cycle Q carries the first (MSB) bit of a word.
REQ-009 SHALL have port BUSY, output, 1 bit: high while a word is being shifted out.

Function
REQ-010 SHALL use a two-state FSM: IDLE and SHIFT.
REQ-011 SHALL accept a word at a rising edge where DIN_VALID=1 and DIN_READY=1.
REQ-012 SHALL copy DIN into an internal C_BITS_IN-bit shift register on acceptance; DIN is don't-care at all other edges.
REQ-013 SHALL clear a bit counter of width $clog2(C_BITS_IN) to 0 on acceptance.
REQ-014 SHALL enter SHIFT on acceptance.
REQ-015 SHALL transmit MSB first: word accepted at edge k places DIN[C_BITS_IN-1] on Q in cycle k+1, DIN[C_BITS_IN-1-n] in cycle k+1+n, and DIN[0] in cycle k+C_BITS_IN.
REQ-016 SHALL register Q, FRAME and BUSY; Q, FRAME and BUSY carry no combinational path from inputs.
REQ-017 SHALL drive FRAME=1 only in the cycle Q carries DIN[C_BITS_IN-1]; FRAME is 0 otherwise.
REQ-018 SHALL drive BUSY=1 in every cycle Q carries a word bit; BUSY is 0 otherwise.
REQ-019 SHALL increment the bit counter by 1 per cycle in SHIFT, with no wrap within a word.
REQ-020 SHALL drive DIN_READY=1 in IDLE, and in SHIFT only when the counter equals C_BITS_IN-1 (last bit cycle).
REQ-021 SHALL, on acceptance during the last bit cycle, begin the next word with no gap: next FRAME immediately follows the prior DIN[0] cycle.
REQ-022 SHALL return to IDLE after the last bit when DIN_VALID=0 in the last bit cycle; Q=0 and BUSY=0 from the following cycle.
REQ-023 SHALL hold Q=0, FRAME=0 and BUSY=0 while in IDLE with no transfer.
REQ-024 SHALL ignore DIN_VALID in SHIFT outside the last bit cycle, with no capture and no state effect.
REQ-025 SHALL never drop, duplicate or reorder a bit of an accepted word.

Reset
REQ-026 SHALL, while RST=1, immediately and asynchronously force: FSM=IDLE, counter=0, shift register=0, Q=0, FRAME=0, BUSY=0.
REQ-027 SHALL drive DIN_READY=1 after reset, since the FSM is in IDLE.
REQ-028 SHALL, on reset during SHIFT, abort the word in progress and not resume it.
REQ-029 SHALL make the first acceptance after reset at the first rising edge with RST=0 and DIN_VALID=1.

Verification (C_BITS_IN=8)
REQ-030 Bench SHALL cover single word: DIN=8'hA5 accepted at edge k -> Q=1,0,1,0,0,1,0,1 in cycles k+1..k+8, FRAME=1 only in k+1, BUSY=1 in k+1..k+8, Q=0 and BUSY=0 at k+9.
REQ-031 Bench SHALL cover back-to-back: DIN_VALID held 1 with 8'hFF then 8'h00 -> second acceptance at edge k+8, Q=1 for k+1..k+8 and 0 for k+9..k+16, FRAME=1 at k+1 and k+9.
REQ-032 Bench SHALL cover ignored valid: DIN_VALID pulsed with 8'h3C at cycle k+3 of word 8'h81 -> DIN_READY=0, Q stream stays 1,0,0,0,0,0,0,1, no extra word.
REQ-033 Bench SHALL cover mid-word reset: RST asserted between edges in cycle k+4 of 8'hF0 -> Q, FRAME and BUSY go 0 without a clock edge; DIN_READY=1; next word 8'h0F serialized correctly.
REQ-034 Bench SHALL cover end-to-end: p_s_converter Q wired into the serial-to-parallel converter with CK and RST shared, random words -> each captured parallel word equals the sent DIN.
REQ-035 Bench SHALL cover idle gap: DIN_VALID=0 for 5 cycles between words -> Q=0, FRAME=0, BUSY=0 and DIN_READY=1 throughout the gap.
